// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 widths, MMU size codes,
// fault codes and FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_FUNCT3  = 2'b01;
  localparam logic [1:0] FAULT_IO      = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle and MMU-side request bundle.
interface lsu_core_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [1:0]  resp_fault_code;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, resp_fault_code
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, resp_fault_code
  );
endinterface

interface lsu_mmu_if;
  logic [31:0] m_address;
  logic        m_rw_req;
  logic        m_rw;
  logic [31:0] m_write_data;
  logic [1:0]  m_size;
  logic [31:0] m_read_data;
  logic        m_data_valid;
  logic        m_busy;

  modport master (
    output m_address, m_rw_req, m_rw, m_write_data, m_size,
    input  m_read_data, m_data_valid, m_busy
  );
  modport slave (
    input  m_address, m_rw_req, m_rw, m_write_data, m_size,
    output m_read_data, m_data_valid, m_busy
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Sign/zero extension of right-aligned load data according to funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_funct3)
      F3_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
      F3_BU:   o_data = {24'h000000, i_data[7:0]};
      F3_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
      F3_HU:   o_data = {16'h0000, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the execute stage to the MMU
// rw_req/size handshake, with load extension and fault reporting.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  lsu_core_if.slave    core,
  lsu_mmu_if.master    mmu
);

  logic [1:0]  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_pend_code;
  logic [7:0]  r_cnt;
  logic [31:0] r_m_address;
  logic        r_m_rw_req;
  logic        r_m_rw;
  logic [31:0] r_m_write_data;
  logic [1:0]  r_m_size;
  logic [31:0] r_resp_rdata;
  logic        r_resp_fault;
  logic [1:0]  r_resp_fault_code;

  logic        w_accept;
  logic [1:0]  w_fault_code;
  logic [7:0]  w_cnt_next;
  logic        w_timeout;
  logic [31:0] w_ext;

  assign core.req_ready = (r_state == S_IDLE) && !mmu.m_busy && !reset;
  assign w_accept       = core.req_valid && core.req_ready;
  assign w_fault_code   = !funct3_legal(core.req_we, core.req_funct3) ? FAULT_FUNCT3 :
                          core.req_addr[31]                           ? FAULT_IO     :
                                                                        FAULT_NONE;
  assign w_cnt_next     = r_cnt + 8'd1;
  assign w_timeout      = (w_cnt_next == 8'(TIMEOUT_CYCLES));

  load_extend u_load_extend (
    .i_funct3 (r_funct3),
    .i_data   (mmu.m_read_data),
    .o_data   (w_ext)
  );

  // Faulted requests still pass through one ACCESS cycle (with m_rw_req low)
  // so that faults and zero-latency accesses share the same response timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_we              <= 1'b0;
      r_funct3          <= '0;
      r_pend_code       <= FAULT_NONE;
      r_cnt             <= '0;
      r_m_address       <= '0;
      r_m_rw_req        <= 1'b0;
      r_m_rw            <= 1'b0;
      r_m_write_data    <= '0;
      r_m_size          <= '0;
      r_resp_rdata      <= '0;
      r_resp_fault      <= 1'b0;
      r_resp_fault_code <= FAULT_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= core.req_we;
            r_funct3    <= core.req_funct3;
            r_pend_code <= w_fault_code;
            r_cnt       <= '0;
            r_state     <= S_ACCESS;
            if (w_fault_code == FAULT_NONE) begin
              r_m_rw_req     <= 1'b1;
              r_m_address    <= core.req_addr;
              r_m_rw         <= core.req_we;
              r_m_write_data <= core.req_wdata;
              r_m_size       <= core.req_funct3[1:0];
            end
          end
        end
        S_ACCESS: begin
          r_cnt <= w_cnt_next;
          if (r_pend_code != FAULT_NONE) begin
            r_state           <= S_RESP;
            r_resp_rdata      <= '0;
            r_resp_fault      <= 1'b1;
            r_resp_fault_code <= r_pend_code;
          end else if (mmu.m_data_valid) begin
            r_m_rw_req        <= 1'b0;
            r_state           <= S_RESP;
            r_resp_rdata      <= r_we ? '0 : w_ext;
            r_resp_fault      <= 1'b0;
            r_resp_fault_code <= FAULT_NONE;
          end else if (w_timeout) begin
            r_m_rw_req        <= 1'b0;
            r_state           <= S_RESP;
            r_resp_rdata      <= '0;
            r_resp_fault      <= 1'b1;
            r_resp_fault_code <= FAULT_TIMEOUT;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core.resp_valid      = (r_state == S_RESP);
  assign core.resp_rdata      = r_resp_rdata;
  assign core.resp_fault      = r_resp_fault;
  assign core.resp_fault_code = r_resp_fault_code;

  assign mmu.m_address    = r_m_address;
  assign mmu.m_rw_req     = r_m_rw_req;
  assign mmu.m_rw         = r_m_rw;
  assign mmu.m_write_data = r_m_write_data;
  assign mmu.m_size       = r_m_size;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scripted MMU responder.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  lsu_core_if core ();
  lsu_mmu_if  mmu ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .core  (core.slave),
    .mmu   (mmu.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // lat: ACCESS cycle on which m_data_valid is raised (0 = never)
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input logic [31:0] mdata,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_code);
    int  k;
    int  c;
    int  held;
    int  exp_cyc;
    int  exp_held;
    logic unstable;
    logic mmu_op;
    mmu_op   = (exp_code == FAULT_NONE) || (exp_code == FAULT_TIMEOUT);
    exp_cyc  = !mmu_op ? 2 : (exp_code == FAULT_TIMEOUT) ? TO + 1 : lat + 1;
    exp_held = !mmu_op ? 0 : (exp_code == FAULT_TIMEOUT) ? TO : lat;
    k = 0;
    while (!core.req_ready && k < 20) begin
      step;
      k++;
    end
    check({tag, ".ready"}, 32'(core.req_ready), 32'd1);
    core.req_valid  = 1'b1;
    core.req_we     = we;
    core.req_funct3 = f3;
    core.req_addr   = addr;
    core.req_wdata  = wdata;
    step;
    core.req_valid = 1'b0;
    if (mmu_op) begin
      mmu.m_busy = 1'b1;
      check({tag, ".m_rw"}, 32'(mmu.m_rw), 32'(we));
      check({tag, ".m_size"}, 32'(mmu.m_size), 32'(f3[1:0]));
      check({tag, ".m_wdata"}, mmu.m_write_data, wdata);
    end
    c = 1;
    held = 0;
    unstable = 1'b0;
    while (c <= 40) begin
      if (mmu.m_rw_req) begin
        held++;
        if (mmu.m_address !== addr || mmu.m_size !== f3[1:0]) unstable = 1'b1;
      end
      if (c == lat) begin
        mmu.m_data_valid = 1'b1;
        mmu.m_read_data  = mdata;
      end
      step;
      mmu.m_data_valid = 1'b0;
      c++;
      if (core.resp_valid) break;
    end
    check({tag, ".resp_valid"}, 32'(core.resp_valid), 32'd1);
    check({tag, ".resp_cycle"}, 32'(c), 32'(exp_cyc));
    check({tag, ".rw_req_cycles"}, 32'(held), 32'(exp_held));
    check({tag, ".m_stable"}, 32'(unstable), 32'd0);
    check({tag, ".rdata"}, core.resp_rdata, exp_rdata);
    check({tag, ".fault"}, 32'(core.resp_fault), 32'(exp_code != FAULT_NONE));
    check({tag, ".code"}, 32'(core.resp_fault_code), 32'(exp_code));
    check({tag, ".rw_req_drop"}, 32'(mmu.m_rw_req), 32'd0);
    step;
    check({tag, ".pulse"}, 32'(core.resp_valid), 32'd0);
    check({tag, ".rdata_hold"}, core.resp_rdata, exp_rdata);
    check({tag, ".ready_busy"}, 32'(core.req_ready), 32'(!mmu_op));
    mmu.m_busy = 1'b0;
    #1;
    check({tag, ".ready_idle"}, 32'(core.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset = 1'b1;
    core.req_valid = 1'b0;
    core.req_we = 1'b0;
    core.req_funct3 = '0;
    core.req_addr = '0;
    core.req_wdata = '0;
    mmu.m_read_data = '0;
    mmu.m_data_valid = 1'b0;
    mmu.m_busy = 1'b0;
    step;
    step;
    check("rst.ready", 32'(core.req_ready), 32'd0);
    check("rst.rw_req", 32'(mmu.m_rw_req), 32'd0);
    check("rst.resp_valid", 32'(core.resp_valid), 32'd0);
    check("rst.fault", 32'(core.resp_fault), 32'd0);
    check("rst.rdata", core.resp_rdata, 32'h0);
    check("rst.code", 32'(core.resp_fault_code), 32'd0);
    check("rst.m_address", mmu.m_address, 32'h0);
    check("rst.m_wdata", mmu.m_write_data, 32'h0);
    reset = 1'b0;
    #1;
    check("rst.ready_after", 32'(core.req_ready), 32'd1);

    run_op("lb",      1'b0, F3_B,   32'h0000_0101, 32'h0, 3, 32'h0000_00F0, 32'hFFFF_FFF0, FAULT_NONE);
    run_op("lhu",     1'b0, F3_HU,  32'h0001_0002, 32'h0, 2, 32'h0000_ABCD, 32'h0000_ABCD, FAULT_NONE);
    run_op("sw",      1'b1, F3_W,   32'h0000_0004, 32'hDEAD_BEEF, 2, 32'h1234_5678, 32'h0, FAULT_NONE);
    run_op("io",      1'b0, F3_W,   32'h8000_0000, 32'h0, 1, 32'h5555_5555, 32'h0, FAULT_IO);
    run_op("f3_011",  1'b0, 3'b011, 32'h0000_0000, 32'h0, 1, 32'h5555_5555, 32'h0, FAULT_FUNCT3);
    run_op("prio",    1'b1, F3_BU,  32'h8000_0010, 32'h1, 1, 32'h5555_5555, 32'h0, FAULT_FUNCT3);
    run_op("timeout", 1'b0, F3_B,   32'h0000_0020, 32'h0, 0, 32'h0, 32'h0, FAULT_TIMEOUT);
    run_op("lw_edge", 1'b0, F3_W,   32'h0000_0024, 32'h0, TO, 32'h89AB_CDEF, 32'h89AB_CDEF, FAULT_NONE);
    run_op("lh_neg",  1'b0, F3_H,   32'h0000_0003, 32'h0, 1, 32'h0000_8001, 32'hFFFF_8001, FAULT_NONE);
    run_op("lh_pos",  1'b0, F3_H,   32'h0000_0006, 32'h0, 2, 32'h1234_7FFF, 32'h0000_7FFF, FAULT_NONE);
    run_op("lbu",     1'b0, F3_BU,  32'h0000_0007, 32'h0, 1, 32'hFFFF_FF80, 32'h0000_0080, FAULT_NONE);
    run_op("lb_pos",  1'b0, F3_B,   32'h0000_0009, 32'h0, 1, 32'hFFFF_FF7F, 32'h0000_007F, FAULT_NONE);
    run_op("sb",      1'b1, F3_B,   32'h0000_000B, 32'h0000_00AB, 1, 32'hFFFF_FFFF, 32'h0, FAULT_NONE);

    // reset during the second ACCESS cycle
    core.req_valid  = 1'b1;
    core.req_we     = 1'b0;
    core.req_funct3 = F3_W;
    core.req_addr   = 32'h0000_0040;
    step;
    core.req_valid = 1'b0;
    mmu.m_busy = 1'b1;
    check("abort.rw_req_on", 32'(mmu.m_rw_req), 32'd1);
    step;
    reset = 1'b1;
    #1;
    check("abort.rw_req_off", 32'(mmu.m_rw_req), 32'd0);
    check("abort.ready_in_rst", 32'(core.req_ready), 32'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      if (core.resp_valid) seen++;
    end
    mmu.m_busy = 1'b0;
    reset = 1'b0;
    #1;
    check("abort.ready", 32'(core.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step;
      if (core.resp_valid) seen++;
    end
    check("abort.no_resp", 32'(seen), 32'd0);
    run_op("recover", 1'b0, F3_W, 32'h0000_0044, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, FAULT_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
